// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one vector-regfile write port among NREQ burst writers.
// The winner keeps the port for its whole burst; writes leave from registered outputs one cycle after each beat.
module regfile_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int ROW       = 16,
    parameter int ROW_WIDTH = $clog2(ROW),
    parameter int WIDTH     = 256,
    parameter int LEN_W     = 3,
    parameter int GID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ROW_WIDTH-1:0]  req_addr,
    input  logic [NREQ*LEN_W-1:0]      req_len,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic                       bank_wen,
    output logic [ROW_WIDTH-1:0]       bank_waddr,
    output logic [WIDTH-1:0]           bank_wdata,
    output logic                       busy,
    output logic [GID_W-1:0]           grant_id
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;
    localparam int   SW       = ROW_WIDTH + LEN_W;
    localparam bit   POW2     = (ROW == (1 << ROW_WIDTH));

    logic                 state;
    logic [GID_W-1:0]     rr_ptr;
    logic [ROW_WIDTH-1:0] base;
    logic [LEN_W-1:0]     burst_len;
    logic [LEN_W-1:0]     cnt;

    logic [ROW_WIDTH-1:0] addr_arr [NREQ];
    logic [LEN_W-1:0]     len_arr  [NREQ];
    logic [WIDTH-1:0]     data_arr [NREQ];

    logic [GID_W-1:0]     winner;
    logic                 any_valid;
    logic                 beat;
    logic                 last_beat;
    logic [SW-1:0]        row_sum;
    logic [ROW_WIDTH-1:0] waddr_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign addr_arr[i]  = req_addr[i*ROW_WIDTH +: ROW_WIDTH];
        assign len_arr[i]   = req_len[i*LEN_W +: LEN_W];
        assign data_arr[i]  = req_data[i*WIDTH +: WIDTH];
        assign req_ready[i] = (state == ST_BURST) && (grant_id == GID_W'(i));
    end

    assign busy      = (state == ST_BURST);
    assign beat      = (state == ST_BURST) && req_valid[grant_id];
    assign last_beat = beat && (cnt == burst_len);

    function automatic logic [GID_W-1:0] next_id(input logic [GID_W-1:0] g);
        return (int'(g) >= NREQ - 1) ? '0 : g + 1'b1;
    endfunction

    // Scan downwards so the candidate closest to rr_ptr overwrites the others.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                winner    = GID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        row_sum = SW'(base) + SW'(cnt);
        if (POW2) begin
            waddr_next = row_sum[ROW_WIDTH-1:0];
        end else if (row_sum >= SW'(ROW)) begin
            waddr_next = ROW_WIDTH'(row_sum - SW'(ROW));
        end else begin
            waddr_next = row_sum[ROW_WIDTH-1:0];
        end
    end

    // A beat handshaken alongside flush still reaches the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_wen   <= 1'b0;
            bank_waddr <= '0;
            bank_wdata <= '0;
        end else begin
            bank_wen <= beat;
            if (beat) begin
                bank_waddr <= waddr_next;
                bank_wdata <= data_arr[grant_id];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            base      <= '0;
            burst_len <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush && any_valid) begin
                        state     <= ST_BURST;
                        grant_id  <= winner;
                        base      <= addr_arr[winner];
                        burst_len <= len_arr[winner];
                        cnt       <= '0;
                    end
                end
                ST_BURST: begin
                    if (flush || last_beat) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        rr_ptr <= next_id(grant_id);
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized + directed bench: requester drivers feed a transaction-level arbiter model
// that predicts grants and bank writes; a monitor pops expected writes as the bank is written.
module tb_regfile_wr_arbiter;

    localparam int N   = 4;
    localparam int ROW = 16;
    localparam int RW  = 4;
    localparam int W   = 256;
    localparam int LW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*RW-1:0]  req_addr;
    logic [N*LW-1:0]  req_len;
    logic [N*W-1:0]   req_data;
    logic             bank_wen;
    logic [RW-1:0]    bank_waddr;
    logic [W-1:0]     bank_wdata;
    logic             busy;
    logic [1:0]       grant_id;

    regfile_wr_arbiter #(.NREQ(N), .ROW(ROW), .WIDTH(W), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_data(req_data),
        .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   passes = 0;

    // reference model: whole-burst view of the port owner
    bit   m_busy;
    int   m_owner, m_rr, m_base, m_len, m_cnt;
    bit   m_wen;

    // requester drivers
    int           rem[N], b_addr[N], b_len[N], bursts_left[N], off_cnt[N];
    int           fix_addr[N], fix_len[N];
    logic [W-1:0] b_data[N];
    int           stall_pct, flush_pct, stall_req, fl_req;

    int   wr_addr_q[$], wr_t_q[$], g_seq[$], g_t[$];
    bit   prev_busy;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chk_q(input string nm, input int got[$], input int exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) chk(nm, got[k], exp[k]);
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic start_burst(input int i);
        if (bursts_left[i] > 0) begin
            bursts_left[i]--;
            b_addr[i] = (fix_addr[i] >= 0) ? fix_addr[i] : int'($urandom_range(ROW - 1));
            b_len[i]  = (fix_len[i] >= 0) ? fix_len[i] : int'($urandom_range(7));
            b_data[i] = rand_data();
            rem[i]    = b_len[i] + 1;
        end else begin
            rem[i] = 0;
        end
    endtask

    task automatic cfg(input int i, input int nb, input int fa, input int fl);
        bursts_left[i] = nb;
        fix_addr[i]    = fa;
        fix_len[i]     = fl;
        start_burst(i);
    endtask

    task automatic clear_tb();
        m_busy = 0; m_owner = 0; m_rr = 0; m_base = 0; m_len = 0; m_cnt = 0; m_wen = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; bursts_left[i] = 0; off_cnt[i] = 0;
            b_addr[i] = 0; b_len[i] = 0; b_data[i] = '0;
            fix_addr[i] = -1; fix_len[i] = -1;
        end
        req_valid = '0; req_addr = '0; req_len = '0; req_data = '0; flush = 1'b0;
        stall_pct = 0; flush_pct = 0; stall_req = -1; fl_req = -1; prev_busy = 0;
    endtask

    task automatic drive();
        bit fl;
        for (int i = 0; i < N; i++) begin
            bit v;
            v = (rem[i] > 0) && (int'($urandom_range(99)) >= stall_pct);
            if (off_cnt[i] > 0) begin
                v = 0;
                off_cnt[i]--;
            end
            req_valid[i]          = v;
            req_addr[i*RW +: RW]  = RW'(b_addr[i]);
            req_len[i*LW +: LW]   = LW'(b_len[i]);
            req_data[i*W +: W]    = b_data[i];
        end
        fl = (flush_pct > 0) && (int'($urandom_range(99)) < flush_pct);
        if (fl_req >= 0 && m_busy && m_owner == fl_req && m_cnt == 2 && req_valid[fl_req]) begin
            fl     = 1;
            fl_req = -1;
        end
        flush = fl;
    endtask

    task automatic model_step();
        int  o;
        bit  beat, last;
        wr_t e;
        o    = m_owner;
        beat = m_busy && req_valid[o];
        last = beat && (m_cnt == m_len);
        m_wen = beat;
        if (beat) begin
            e.addr = (m_base + m_cnt) % ROW;
            e.data = b_data[o];
            exp_q.push_back(e);
            rem[o]--;
            b_data[o] = rand_data();
            if (stall_req == o && m_cnt == 0) begin
                off_cnt[o] = 3;
                stall_req  = -1;
            end
            if (rem[o] == 0) start_burst(o);
        end
        if (m_busy && flush) begin
            m_busy = 0; m_cnt = 0; m_rr = (o + 1) % N;
            if (!last) begin
                rem[o] = 0;
                start_burst(o);
            end
        end else if (m_busy) begin
            if (last) begin
                m_busy = 0; m_cnt = 0; m_rr = (o + 1) % N;
            end else if (beat) begin
                m_cnt++;
            end
        end else if (!flush && req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (req_valid[idx] && !m_busy) begin
                    m_busy = 1; m_owner = idx; m_base = b_addr[idx]; m_len = b_len[idx]; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] er;
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        er = '0;
        if (m_busy) er[m_owner] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, m_owner);
        chk("bank_wen", bank_wen, m_wen);
        if (busy && !prev_busy) begin
            g_seq.push_back(int'(grant_id));
            g_t.push_back(int'($time / 10));
        end
        prev_busy = busy;
    endtask

    function automatic bit phase_done();
        for (int i = 0; i < N; i++)
            if (rem[i] != 0 || bursts_left[i] != 0 || off_cnt[i] != 0) return 0;
        return !m_busy;
    endfunction

    task automatic run_phase(input string nm, input int budget);
        int n;
        n = 0;
        while (!phase_done() && n < budget) begin
            step();
            n++;
        end
        if (!phase_done()) begin
            checks++;
            $display("FAIL %s_timeout: got %0d cycles want completion within %0d", nm, n, budget);
        end
        step();
        step();
    endtask

    task automatic clear_obs();
        wr_addr_q.delete(); wr_t_q.delete(); g_seq.delete(); g_t.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bank_wen === 1'b1) begin
            wr_addr_q.push_back(int'(bank_waddr));
            wr_t_q.push_back(int'($time / 10));
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got row %0d want no write", bank_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bank_waddr", bank_waddr, mon_e.addr);
                chk("bank_wdata", bank_wdata, mon_e.data);
            end
        end
    end

    initial begin
        int eq[$];
        rst_n = 1'b0;
        clear_tb();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wen", bank_wen, 0);
        chk("rst_waddr", bank_waddr, 0);
        chk("rst_wdata", bank_wdata, 0);
        chk("rst_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single burst, back to back
        clear_obs();
        cfg(0, 1, 3, 3);
        run_phase("single", 100);
        eq = {3, 4, 5, 6};
        chk_q("single_rows", wr_addr_q, eq);
        for (int k = 1; k < 4 && k < wr_t_q.size(); k++) chk("single_spacing", wr_t_q[k] - wr_t_q[0], k);

        // wrap past the last row
        clear_obs();
        cfg(1, 1, 14, 3);
        run_phase("wrap", 100);
        eq = {14, 15, 0, 1};
        chk_q("wrap_rows", wr_addr_q, eq);

        // round robin from reset, single-beat bursts
        rst_n = 1'b0;
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        cfg(0, 2, -1, 0);
        cfg(1, 1, -1, 0);
        cfg(2, 1, -1, 0);
        cfg(3, 1, -1, 0);
        run_phase("rr", 200);
        eq = {0, 1, 2, 3, 0};
        chk_q("rr_order", g_seq, eq);
        for (int k = 1; k < g_t.size(); k++) chk("rr_burst_cycles", g_t[k] - g_t[k-1], 2);

        // stall: req2 drops valid for 3 cycles after its first beat, req0 waits
        clear_obs();
        stall_req = 2;
        cfg(2, 1, 5, 2);
        cfg(0, 1, 9, 0);
        run_phase("stall", 200);
        eq = {5, 6, 7, 9};
        chk_q("stall_rows", wr_addr_q, eq);
        if (wr_t_q.size() >= 3) begin
            chk("stall_gap", wr_t_q[1] - wr_t_q[0], 4);
            chk("stall_resume", wr_t_q[2] - wr_t_q[1], 1);
        end

        // flush on the third beat of a len=7 burst
        clear_obs();
        fl_req = 1;
        cfg(1, 1, 0, 7);
        cfg(3, 1, 10, 0);
        cfg(0, 1, 11, 0);
        run_phase("flush", 200);
        eq = {0, 1, 2, 10, 11};
        chk_q("flush_rows", wr_addr_q, eq);
        eq = {1, 3, 0};
        chk_q("flush_grants", g_seq, eq);

        // asynchronous reset in the middle of a burst
        cfg(3, 1, 4, 7);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_wen", bank_wen, 0);
        chk("arst_waddr", bank_waddr, 0);
        chk("arst_wdata", bank_wdata, 0);
        chk("arst_grant", grant_id, 0);
        clear_tb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < N; i++) cfg(i, 1, -1, -1);
        run_phase("post_reset", 300);
        if (g_seq.size() > 0) chk("post_reset_first_grant", g_seq[0], 0);
        else chk("post_reset_grants", g_seq.size(), N);

        // random traffic with stalls and flushes
        stall_pct = 25;
        flush_pct = 4;
        for (int i = 0; i < N; i++) cfg(i, 6, -1, -1);
        run_phase("random", 4000);
        flush_pct = 0;
        step();
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
